seg7_scanner: RTL and testbench

SEG7_SCANNER -- requirements
Module: seg7_scanner

---
 rtl/seg7_scanner.sv | 111 +++++++++++
 tb/tb_seg7_scanner.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/seg7_scanner.sv
`default_nettype none
// ============================================================================
// Module      : seg7_scanner
// Description : Four-digit hex scanner for a multiplexed 7-segment display.
//               Define SEG7_FRAME_SYNC_EN to hold new data until a frame ends.
// Revision    : 1.0 - initial release
// ============================================================================
module seg7_scanner #(
    parameter int REFRESH_DIV = 100000
) (
    input  logic        CLK,
    input  logic        RESETN,
    input  logic [15:0] DATA_IN,
    input  logic        DATA_VALID,
    output logic        DATA_READY,
    output logic [1:0]  SEG_SELECT_OUT,
    output logic [3:0]  NUMBER_OUT,
    output logic        FRAME_TICK
);

    localparam int c_CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(REFRESH_DIV - 1);

    logic [c_CNT_W-1:0] r_cnt;
    logic [1:0]         r_idx;
    logic [15:0]        r_disp;
    logic [3:0]         r_num;
    logic               r_tick;
    logic               r_ready;

    logic               w_tc;
    logic               w_frame_end;
    logic               w_accept;
    logic               w_ready_next;
    logic [1:0]         w_idx_next;
    logic [3:0]         w_digit;

    assign w_tc        = (r_cnt == c_CNT_MAX);
    assign w_frame_end = w_tc && (r_idx == 2'd3);
    assign w_accept    = DATA_VALID && r_ready;
    assign w_idx_next  = w_tc ? (r_idx + 2'd1) : r_idx;

    // Digit is looked up with the index that becomes visible on this edge,
    // keeping select and number aligned.
    always_comb begin
        w_digit = 4'h0;
        case (w_idx_next)
            2'd0: w_digit = r_disp[3:0];
            2'd1: w_digit = r_disp[7:4];
            2'd2: w_digit = r_disp[11:8];
            2'd3: w_digit = r_disp[15:12];
            default: w_digit = 4'h0;
        endcase
    end

`ifdef SEG7_FRAME_SYNC_EN
    logic [15:0] r_pend;
    logic        r_pend_vld;

    // Ready is low whenever pending holds data, so accept and frame copy
    // never collide on the same cycle.
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            r_pend     <= 16'h0000;
            r_pend_vld <= 1'b0;
            r_disp     <= 16'h0000;
        end else if (w_accept) begin
            r_pend     <= DATA_IN;
            r_pend_vld <= 1'b1;
        end else if (w_frame_end && r_pend_vld) begin
            r_disp     <= r_pend;
            r_pend_vld <= 1'b0;
        end
    end

    assign w_ready_next = !(w_accept || (r_pend_vld && !w_frame_end));
`else
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            r_disp <= 16'h0000;
        end else if (w_accept) begin
            r_disp <= DATA_IN;
        end
    end

    assign w_ready_next = 1'b1;
`endif

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            r_cnt   <= '0;
            r_idx   <= 2'd0;
            r_num   <= 4'h0;
            r_tick  <= 1'b0;
            r_ready <= 1'b0;
        end else begin
            r_cnt   <= w_tc ? '0 : (r_cnt + c_CNT_W'(1));
            r_idx   <= w_idx_next;
            r_num   <= w_digit;
            r_tick  <= w_frame_end;
            r_ready <= w_ready_next;
        end
    end

    assign SEG_SELECT_OUT = r_idx;
    assign NUMBER_OUT     = r_num;
    assign FRAME_TICK     = r_tick;
    assign DATA_READY     = r_ready;

endmodule
`default_nettype wire

// File: tb/tb_seg7_scanner.sv
`default_nettype none
// ============================================================================
// Module      : tb_seg7_scanner
// Description : Directed self-checking bench for seg7_scanner, REFRESH_DIV=4.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seg7_scanner;

    localparam int c_DIV = 4;

    logic        CLK = 1'b0;
    logic        RESETN;
    logic [15:0] DATA_IN;
    logic        DATA_VALID;
    logic        DATA_READY;
    logic [1:0]  SEG_SELECT_OUT;
    logic [3:0]  NUMBER_OUT;
    logic        FRAME_TICK;

    int n_tests = 0;
    int n_fail  = 0;
    int k       = 0;

    // Digits per index 0..3, written out by hand.
    logic [3:0] exp_1a2f [4] = '{4'hF, 4'h2, 4'hA, 4'h1};
    logic [3:0] exp_beef [4] = '{4'hF, 4'hE, 4'hE, 4'hB};
    logic [3:0] exp_1234 [4] = '{4'h4, 4'h3, 4'h2, 4'h1};
    logic [3:0] exp_5678 [4] = '{4'h8, 4'h7, 4'h6, 4'h5};

    seg7_scanner #(.REFRESH_DIV(c_DIV)) dut (
        .CLK            (CLK),
        .RESETN         (RESETN),
        .DATA_IN        (DATA_IN),
        .DATA_VALID     (DATA_VALID),
        .DATA_READY     (DATA_READY),
        .SEG_SELECT_OUT (SEG_SELECT_OUT),
        .NUMBER_OUT     (NUMBER_OUT),
        .FRAME_TICK     (FRAME_TICK)
    );

    always #5 CLK = ~CLK;

    // k counts rising edges since the last reset release.
    task automatic adv();
        @(negedge CLK);
        k++;
    endtask

    task automatic adv_n(input int n);
        repeat (n) adv();
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s (k=%0d): observed %0h, expected %0h", tag, k, obs, exp);
        end
    endtask

    function automatic logic [1:0] sel_at(input int kk);
        return 2'((kk / c_DIV) % 4);
    endfunction

    initial begin
        RESETN     = 1'b0;
        DATA_IN    = 16'h0000;
        DATA_VALID = 1'b0;
        repeat (3) @(negedge CLK);
        chk("rst_sel",   16'(SEG_SELECT_OUT), 16'h0);
        chk("rst_num",   16'(NUMBER_OUT),     16'h0);
        chk("rst_tick",  16'(FRAME_TICK),     16'h0);
        chk("rst_ready", 16'(DATA_READY),     16'h0);

        RESETN = 1'b1;
        k = 0;
        for (int i = 0; i < 33; i++) begin
            adv();
            chk("scan_sel",   16'(SEG_SELECT_OUT), 16'(sel_at(k)));
            chk("scan_tick",  16'(FRAME_TICK), (k % 16 == 0) ? 16'h1 : 16'h0);
            chk("scan_ready", 16'(DATA_READY), 16'h1);
            chk("scan_num",   16'(NUMBER_OUT), 16'h0);
        end

`ifndef SEG7_FRAME_SYNC_EN
        // Single-cycle write goes straight to the display.
        DATA_IN    = 16'h1A2F;
        DATA_VALID = 1'b1;
        adv();
        DATA_VALID = 1'b0;
        DATA_IN    = 16'h0000;
        adv();
        chk("wr_num_next", 16'(NUMBER_OUT), 16'hF);
        for (int i = 0; i < 16; i++) begin
            adv();
            chk("wr_sel", 16'(SEG_SELECT_OUT), 16'(sel_at(k)));
            chk("wr_num", 16'(NUMBER_OUT), 16'(exp_1a2f[sel_at(k)]));
        end
        DATA_IN = 16'hFFFF;
        for (int i = 0; i < 10; i++) begin
            adv();
            chk("ign_num",   16'(NUMBER_OUT), 16'(exp_1a2f[sel_at(k)]));
            chk("ign_ready", 16'(DATA_READY), 16'h1);
        end
`else
        adv_n(4);
        DATA_IN    = 16'hBEEF;
        DATA_VALID = 1'b1;
        adv();
        DATA_VALID = 1'b0;
        DATA_IN    = 16'h0000;
        chk("fs_ready_drop", 16'(DATA_READY), 16'h0);
        for (int i = 0; i < 9; i++) begin
            adv();
            chk("fs_hold_ready", 16'(DATA_READY), 16'h0);
            chk("fs_hold_num",   16'(NUMBER_OUT), 16'h0);
        end
        adv();
        chk("fs_bnd_ready", 16'(DATA_READY), 16'h1);
        chk("fs_bnd_tick",  16'(FRAME_TICK), 16'h1);
        chk("fs_bnd_sel",   16'(SEG_SELECT_OUT), 16'h0);
        for (int i = 0; i < 15; i++) begin
            adv();
            chk("fs_beef_num", 16'(NUMBER_OUT), 16'(exp_beef[sel_at(k)]));
        end

        // Valid held high across two words: second waits for ready.
        DATA_IN    = 16'h1234;
        DATA_VALID = 1'b1;
        adv();
        DATA_IN    = 16'h5678;
        for (int i = 0; i < 15; i++) begin
            adv();
            chk("bp_ready", 16'(DATA_READY), 16'h0);
            chk("bp_num",   16'(NUMBER_OUT), 16'(exp_beef[sel_at(k)]));
        end
        adv();
        chk("bp_ready_back", 16'(DATA_READY), 16'h1);
        adv();
        chk("bp_ready_2nd", 16'(DATA_READY), 16'h0);
        chk("bp_1234_num",  16'(NUMBER_OUT), 16'(exp_1234[sel_at(k)]));
        DATA_VALID = 1'b0;
        DATA_IN    = 16'h0000;
        for (int i = 0; i < 14; i++) begin
            adv();
            chk("bp_1234_num", 16'(NUMBER_OUT), 16'(exp_1234[sel_at(k)]));
        end
        adv();
        chk("bp_ready_end", 16'(DATA_READY), 16'h1);
        for (int i = 0; i < 15; i++) begin
            adv();
            chk("bp_5678_num", 16'(NUMBER_OUT), 16'(exp_5678[sel_at(k)]));
        end

        // Leave a word pending when reset hits.
        DATA_IN    = 16'hAAAA;
        DATA_VALID = 1'b1;
        adv();
        DATA_VALID = 1'b0;
        chk("pend_ready", 16'(DATA_READY), 16'h0);
        adv_n(6);
`endif

        // Mid-frame asynchronous reset, checked between clock edges.
        #2;
        RESETN = 1'b0;
        #1;
        chk("arst_sel",   16'(SEG_SELECT_OUT), 16'h0);
        chk("arst_num",   16'(NUMBER_OUT),     16'h0);
        chk("arst_tick",  16'(FRAME_TICK),     16'h0);
        chk("arst_ready", 16'(DATA_READY),     16'h0);
        repeat (2) @(negedge CLK);
        RESETN = 1'b1;
        k = 0;
        for (int i = 0; i < 40; i++) begin
            adv();
            chk("post_sel",   16'(SEG_SELECT_OUT), 16'(sel_at(k)));
            chk("post_num",   16'(NUMBER_OUT),     16'h0);
            chk("post_ready", 16'(DATA_READY),     16'h1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
